// File: rtl/alu_pkg.sv
// Shared constants and types for the wide-operation sequencer and its 16-bit ALU.
// Select codes are only meaningful together with the mode bit (SUB and XOR share a code).
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    localparam logic [3:0] SEL_ADD    = 4'b1001;
    localparam logic [3:0] SEL_SUB    = 4'b0110;
    localparam logic [3:0] SEL_XOR    = 4'b0110;
    localparam logic [3:0] SEL_PASS_A = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_wide_seq_if.sv
// Request/ALU/result bundle between the wide sequencer (slave) and its environment (master).
// result_zero only exists when ALU_WIDE_ZERO_FLAG_EN is defined.
interface alu_wide_seq_if #(
    parameter int WORDS = 4
);
    import alu_pkg::*;

    logic                     start_valid;
    logic                     start_ready;
    logic                     op_mode;
    logic [3:0]               op_select;
    logic                     op_carry_in;
    logic [WORDS*ALU_W-1:0]   op_a;
    logic [WORDS*ALU_W-1:0]   op_b;

    logic [ALU_W-1:0]         alu_in_a;
    logic [ALU_W-1:0]         alu_in_b;
    logic [3:0]               alu_select;
    logic                     alu_mode;
    logic                     alu_carry_in;
    logic [ALU_W-1:0]         alu_result;
    logic                     alu_carry_out;

    logic                     result_valid;
    logic                     result_ready;
    logic [WORDS*ALU_W-1:0]   result;
    logic                     result_carry;
`ifdef ALU_WIDE_ZERO_FLAG_EN
    logic                     result_zero;
`endif

    modport slave (
        input  start_valid, op_mode, op_select, op_carry_in, op_a, op_b,
        input  alu_result, alu_carry_out, result_ready,
        output start_ready, alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
        output result_valid, result, result_carry
`ifdef ALU_WIDE_ZERO_FLAG_EN
        , output result_zero
`endif
    );

    modport master (
        output start_valid, op_mode, op_select, op_carry_in, op_a, op_b,
        output alu_result, alu_carry_out, result_ready,
        input  start_ready, alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
        input  result_valid, result, result_carry
`ifdef ALU_WIDE_ZERO_FLAG_EN
        , input result_zero
`endif
    );

endinterface

// File: rtl/alu_wide_seq.sv
// Issues one WORDS x 16-bit operation to the ALU a word per cycle (LSW first), chaining carry/borrow.
// Latency: accept at edge T, result_valid after edge T+WORDS; one idle cycle minimum between ops.
// Backpressure: result held in DONE until result_ready; start_ready only in IDLE. Option: ALU_WIDE_ZERO_FLAG_EN.
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_wide_seq_if.slave bus
);

    localparam int DATA_W = ALU_W;
    localparam int WIDE_W = WORDS * DATA_W;
    localparam int IDX_W  = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t              state;
    logic [WIDE_W-1:0]   a_q;
    logic [WIDE_W-1:0]   b_q;
    logic [WIDE_W-1:0]   result_q;
    logic [3:0]          sel_q;
    logic                mode_q;
    logic                carry_q;
    logic                result_carry_q;
    logic [IDX_W-1:0]    idx;
`ifdef ALU_WIDE_ZERO_FLAG_EN
    logic                zero_q;
`endif

    logic run;
    logic carry_next;

    assign run = (state == RUN);
    // Logic-mode ALU carry_out is meaningless, so it never enters the chain.
    assign carry_next = (mode_q == MODE_ARITH) ? bus.alu_carry_out : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            result_q       <= '0;
            sel_q          <= '0;
            mode_q         <= MODE_ARITH;
            carry_q        <= 1'b0;
            result_carry_q <= 1'b0;
            idx            <= '0;
`ifdef ALU_WIDE_ZERO_FLAG_EN
            zero_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q            <= bus.op_a;
                        b_q            <= bus.op_b;
                        sel_q          <= bus.op_select;
                        mode_q         <= bus.op_mode;
                        carry_q        <= (bus.op_mode == MODE_ARITH) ? bus.op_carry_in : 1'b0;
                        result_q       <= '0;
                        result_carry_q <= 1'b0;
                        idx            <= '0;
`ifdef ALU_WIDE_ZERO_FLAG_EN
                        zero_q         <= 1'b1;
`endif
                        state          <= RUN;
                    end
                end
                RUN: begin
                    result_q[idx*DATA_W +: DATA_W] <= bus.alu_result;
                    carry_q <= carry_next;
                    idx     <= idx + 1'b1;
`ifdef ALU_WIDE_ZERO_FLAG_EN
                    zero_q  <= zero_q & (bus.alu_result == '0);
`endif
                    if (idx == LAST_IDX) begin
                        result_carry_q <= carry_next;
                        idx            <= '0;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_ready  = (state == IDLE);
    assign bus.alu_in_a     = run ? a_q[idx*DATA_W +: DATA_W] : '0;
    assign bus.alu_in_b     = run ? b_q[idx*DATA_W +: DATA_W] : '0;
    assign bus.alu_select   = run ? sel_q : '0;
    assign bus.alu_mode     = run ? mode_q : 1'b0;
    assign bus.alu_carry_in = run ? carry_q : 1'b0;

    assign bus.result_valid = (state == DONE);
    assign bus.result       = result_q;
    assign bus.result_carry = result_carry_q;
`ifdef ALU_WIDE_ZERO_FLAG_EN
    assign bus.result_zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu_wide_seq.sv
// Randomised bench for alu_wide_seq: a 16-bit ALU stub drives the word interface and
// whole operations are compared against wide-integer arithmetic (ALU_WIDE_ZERO_FLAG_EN aware).
module tb_alu_wide_seq;
    import alu_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = WORDS * ALU_W;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_wide_seq_if #(.WORDS(WORDS)) bus ();

    alu_wide_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub; in logic mode carry_out is deliberately junk.
    always_comb begin
        logic [16:0] t;
        t = '0;
        bus.alu_result    = '0;
        bus.alu_carry_out = 1'b0;
        if (bus.alu_mode == MODE_ARITH && bus.alu_select == SEL_ADD) begin
            t = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b} + 17'(bus.alu_carry_in);
            bus.alu_result    = t[15:0];
            bus.alu_carry_out = t[16];
        end else if (bus.alu_mode == MODE_ARITH && bus.alu_select == SEL_SUB) begin
            t = {1'b0, bus.alu_in_a} - {1'b0, bus.alu_in_b} - 17'(bus.alu_carry_in);
            bus.alu_result    = t[15:0];
            bus.alu_carry_out = t[16];
        end else if (bus.alu_mode == MODE_LOGIC && bus.alu_select == SEL_XOR) begin
            bus.alu_result    = bus.alu_in_a ^ bus.alu_in_b;
            bus.alu_carry_out = ^bus.alu_in_a;
        end else if (bus.alu_mode == MODE_LOGIC && bus.alu_select == SEL_PASS_A) begin
            bus.alu_result    = bus.alu_in_a;
            bus.alu_carry_out = ~(^bus.alu_in_a);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic mode, input logic [3:0] sel, input logic ci,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic co);
        logic [W:0] t;
        res = '0;
        co  = 1'b0;
        if (mode == MODE_ARITH && sel == SEL_ADD) begin
            t = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
            res = t[W-1:0];
            co  = t[W];
        end else if (mode == MODE_ARITH && sel == SEL_SUB) begin
            t = {1'b0, a} - {1'b0, b} - (W+1)'(ci);
            res = t[W-1:0];
            co  = t[W];
        end else if (mode == MODE_LOGIC && sel == SEL_XOR) begin
            res = a ^ b;
        end else if (mode == MODE_LOGIC && sel == SEL_PASS_A) begin
            res = a;
        end
    endfunction

    // Carry/borrow entering word k, derived from the low k words as plain integers.
    function automatic logic carry_into(input logic mode, input logic [3:0] sel, input logic ci,
                                        input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        logic [W-1:0] mask;
        logic [W:0]   s;
        if (mode == MODE_LOGIC) return 1'b0;
        if (k == 0) return ci;
        mask = (64'd1 << (16 * k)) - 64'd1;
        if (sel == SEL_ADD) begin
            s = {1'b0, a & mask} + {1'b0, b & mask} + (W+1)'(ci);
            return s[16*k];
        end
        if (sel == SEL_SUB) return ({1'b0, a & mask} < ({1'b0, b & mask} + (W+1)'(ci)));
        return 1'b0;
    endfunction

    task automatic run_op(input logic mode, input logic [3:0] sel, input logic ci,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_res;
        logic         exp_co;
        int           valid_at;
        model(mode, sel, ci, a, b, exp_res, exp_co);
        @(negedge clk);
        check("start_ready_idle", 64'(bus.start_ready), 64'd1);
        bus.start_valid = 1'b1;
        bus.op_mode     = mode;
        bus.op_select   = sel;
        bus.op_carry_in = ci;
        bus.op_a        = a;
        bus.op_b        = b;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.op_a        = {$urandom, $urandom};
        bus.op_b        = {$urandom, $urandom};
        bus.op_carry_in = ~ci;
        bus.op_mode     = 1'($urandom);
        valid_at = 0;
        for (int n = 1; n <= WORDS + 4; n++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                valid_at = n;
                break;
            end
            if (n <= WORDS) begin
                check($sformatf("alu_carry_in_w%0d", n - 1), 64'(bus.alu_carry_in),
                      64'(carry_into(mode, sel, ci, a, b, n - 1)));
                check($sformatf("alu_in_a_w%0d", n - 1), 64'(bus.alu_in_a), 64'(a[(n-1)*16 +: 16]));
            end
        end
        check("valid_latency", 64'(valid_at), 64'(WORDS + 1));
        if (valid_at == 0) return;
        check("result", bus.result, exp_res);
        check("result_carry", 64'(bus.result_carry), 64'(exp_co));
`ifdef ALU_WIDE_ZERO_FLAG_EN
        check("result_zero", 64'(bus.result_zero), 64'(exp_res == '0));
`endif
        for (int h = 0; h < hold; h++) begin
            bus.start_valid = (h == 1);
            @(negedge clk);
            check("hold_valid", 64'(bus.result_valid), 64'd1);
            check("hold_result", bus.result, exp_res);
            check("hold_start_ready", 64'(bus.start_ready), 64'd0);
        end
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check("release_valid", 64'(bus.result_valid), 64'd0);
        check("release_start_ready", 64'(bus.start_ready), 64'd1);
        check("idle_result_kept", bus.result, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] sel;
        logic       mode;
        n_tests = 0;
        n_fail  = 0;
        rst_n            = 1'b0;
        bus.start_valid  = 1'b0;
        bus.op_mode      = 1'b0;
        bus.op_select    = '0;
        bus.op_carry_in  = 1'b0;
        bus.op_a         = '0;
        bus.op_b         = '0;
        bus.result_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_start_ready", 64'(bus.start_ready), 64'd1);
        check("rst_result_valid", 64'(bus.result_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_result_carry", 64'(bus.result_carry), 64'd0);
        check("rst_alu_in_a", 64'(bus.alu_in_a), 64'd0);
        check("rst_alu_select", 64'(bus.alu_select), 64'd0);
        rst_n = 1'b1;

        run_op(MODE_ARITH, SEL_ADD, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 0);
        run_op(MODE_ARITH, SEL_ADD, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1);
        run_op(MODE_ARITH, SEL_SUB, 1'b0, 64'h0000_0000_0001_0000, 64'h1, 0);
        run_op(MODE_LOGIC, SEL_XOR, 1'b1, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 0);
        run_op(MODE_ARITH, SEL_ADD, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 6);

        // Asynchronous reset while idx == 2.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.op_mode     = MODE_ARITH;
        bus.op_select   = SEL_ADD;
        bus.op_carry_in = 1'b0;
        bus.op_a        = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.op_b        = 64'h1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_start_ready", 64'(bus.start_ready), 64'd1);
        check("midrun_rst_valid", 64'(bus.result_valid), 64'd0);
        check("midrun_rst_result", bus.result, 64'd0);
        check("midrun_rst_alu_in_a", 64'(bus.alu_in_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(MODE_ARITH, SEL_ADD, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(3))
                0: begin mode = MODE_ARITH; sel = SEL_ADD;    end
                1: begin mode = MODE_ARITH; sel = SEL_SUB;    end
                2: begin mode = MODE_LOGIC; sel = SEL_XOR;    end
                default: begin mode = MODE_LOGIC; sel = SEL_PASS_A; end
            endcase
            if (i % 4 == 3)
                run_op(mode, sel, 1'($urandom), 64'hFFFF_FFFF_FFFF_0000 | 64'($urandom_range(65535)),
                       64'($urandom_range(3)), $urandom_range(3));
            else
                run_op(mode, sel, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                       $urandom_range(3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
Multi-word sequencer sitting directly upstream of the 16-bit ALU. It accepts one wide operation of WORDS x 16 bits and issues it to the ALU one 16-bit word per cycle, least-significant word first. In arithmetic mode it chains the ALU carry/borrow between words. It collects the ALU results into a wide result register and returns them through a valid/ready handshake.

Parameters:
WORDS, 4, number of 16-bit words per operation; legal range 2..8.
DATA_W, 16, ALU word width; fixed, not overridable in practice.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start_valid  input  1  request to begin an operation
start_ready  output  1  sequencer can accept a request
op_mode  input  1  0 = arithmetic, 1 = logic (passed to ALU mode)
op_select  input  4  ALU select code, held for the whole operation
op_carry_in  input  1  initial carry/borrow into word 0
op_a  input  WORDS*16  wide operand A
op_b  input  WORDS*16  wide operand B
alu_in_a  output  16  current word of A to ALU
alu_in_b  output  16  current word of B to ALU
alu_select  output  4  latched select
alu_mode  output  1  latched mode
alu_carry_in  output  1  chained carry to ALU
alu_result  input  16  ALU alu_out, combinational from alu_* outputs
alu_carry_out  input  1  ALU carry_out
result_valid  output  1  wide result available
result_ready  input  1  consumer accepts result
result  output  WORDS*16  wide result
result_carry  output  1  final carry/borrow out of the top word

Behaviour:
- Reset (async, rst_n=0): state=IDLE. start_ready=1, result_valid=0, result=0, result_carry=0, word index=0, carry reg=0. All alu_* outputs are 0.
- States:
  - IDLE:
    - start_ready=1.
    - On start_valid&start_ready: latch op_a, op_b, op_select, op_mode. Set carry reg = op_carry_in if op_mode=0, else 0. Clear result. Set idx=0. Go to RUN.
  - RUN:
    - start_ready=0.
    - Drive alu_in_a=A[idx*16+:16], alu_in_b=B[idx*16+:16], alu_carry_in=carry reg (0 when mode=1).
    - Each edge: result[idx] <= alu_result.
    - Each edge: carry reg <= alu_carry_out if mode=0, else 0.
    - Each edge: idx <= idx+1.
    - When idx==WORDS-1: go to DONE and set result_carry from the last alu_carry_out (0 in logic mode).
  - DONE:
    - result_valid=1. result and result_carry are held stable.
    - On result_ready: go to IDLE with result_valid=0.
    - result register keeps its value until the next accept.
- Latency: accept at edge T; RUN occupies WORDS cycles; result_valid asserts after edge T+WORDS. With WORDS=4, 5 cycles from accept to valid.
- Throughput: start_ready only in IDLE, so there is at least one idle cycle between operations.
- Borrow chaining: for subtract codes the ALU computes A-B-carry_in. The carry_out bit is the borrow and is chained unchanged.
- Select codes that force carry_out=0 simply propagate 0.
- alu_* outputs are 0 outside RUN.
- Reset mid-RUN or mid-DONE: immediate return to IDLE. The partial result is discarded and cleared to 0.
- Input changes on op_* after accept are ignored.

Optional Feature:
Macro ALU_WIDE_ZERO_FLAG_EN.
- Defined: adds output port result_zero (1 bit). It is cleared to 0 on reset, set to 1 on accept, and ANDed with (alu_result==0) each RUN cycle. It is valid with result_valid and held in DONE.
- Undefined: the port and its logic are absent; there is no other behavioural change.

Decomposition:
- Package alu_pkg holds:
  - MODE_ARITH=1'b0 and MODE_LOGIC=1'b1.
  - Select constants SEL_ADD=4'b1001, SEL_SUB=4'b0110, SEL_XOR=4'b0110 (logic), SEL_PASS_A=4'b1111.
  - State typedef {IDLE, RUN, DONE}.
  - ALU_W=16.
- No sub-module. The word mux and result write stay inline; the ALU is instantiated beside this block at the next level up.

Test Plan:
- WORDS=4, ADD (mode 0, sel 1001, ci 0), A=0x0000_0000_0000_FFFF, B=0x1 -> result 0x0000_0000_0001_0000, result_carry 0, valid 5 cycles after accept.
- ADD, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> result 0x0, result_carry 1 (zero flag 1 if ALU_WIDE_ZERO_FLAG_EN).
- SUB (sel 0110, ci 0), A=0x0000_0000_0001_0000, B=0x1 -> result 0x0000_0000_0000_FFFF, result_carry 0. alu_carry_in observed as 1 on word 1.
- Logic XOR (mode 1, sel 0110), A=0xFFFF_0000_FFFF_0000, B=0x0F0F_0F0F_0F0F_0F0F, op_carry_in 1 -> result 0xF0F0_0F0F_F0F0_0F0F. alu_carry_in 0 every cycle, result_carry 0.
- Hold result_ready=0 for 6 cycles in DONE, pulse start_valid -> result and result_valid stable, start_ready 0, no new accept. Release -> IDLE the next cycle.
- Assert rst_n=0 asynchronously at idx=2 of RUN -> same-cycle start_ready=1, result_valid=0, result=0. A new ADD afterwards completes correctly.
